// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic core: default widths and FSM encodings.
// K must be identical on mod_exp_ctrl and the mod_mul it drives.
package mod_arith_pkg;

  localparam int unsigned KDefault    = 12;
  localparam int unsigned LogKDefault = 4;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StSq,
    StMul,
    StFin
  } exp_state_e;

  typedef enum logic [1:0] {
    MmIdle,
    MmRun,
    MmDone
  } mm_state_e;

endpackage

// File: rtl/mod_mul.sv
// Interleaved modular multiplier z = x*y mod M, one multiplier bit per cycle (MSB first).
// Responder side of the level start / pulsed done handshake.
module mod_mul
  import mod_arith_pkg::*;
#(
  parameter int unsigned K    = KDefault,
  parameter int unsigned LOGK = LogKDefault,
  parameter int unsigned M    = 3551
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  output logic [K-1:0] z,
  output logic         done
);

  localparam logic [K+1:0] MExt  = M[K+1:0];
  localparam logic [K+1:0] M2Ext = MExt << 1;

  mm_state_e        state_q, state_d;
  logic [K-1:0]     x_q, x_d;
  logic [K-1:0]     y_q, y_d;
  logic [K-1:0]     p_q, p_d;
  logic [K-1:0]     z_q, z_d;
  logic [LOGK-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [K+1:0]     sum;
  logic [K+1:0]     red;

  // 2p + x < 3M because p, x < M, so at most two subtractions restore p < M.
  always_comb begin
    sum = {1'b0, p_q, 1'b0} + (y_q[cnt_q] ? {2'b00, x_q} : '0);
    if (sum >= M2Ext) begin
      red = sum - M2Ext;
    end else if (sum >= MExt) begin
      red = sum - MExt;
    end else begin
      red = sum;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      MmIdle: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          p_d     = '0;
          cnt_d   = LOGK'(K - 1);
          state_d = MmRun;
        end
      end
      MmRun: begin
        p_d = red[K-1:0];
        if (cnt_q == '0) begin
          z_d     = red[K-1:0];
          done_d  = 1'b1;
          state_d = MmDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MmDone: begin
        state_d = MmIdle;
      end
      default: state_d = MmIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MmIdle;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign z    = z_q;
  assign done = done_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for z = base^exp mod m.
// Initiator of the mod_mul start/done handshake; all outputs are registered.
module mod_exp_ctrl
  import mod_arith_pkg::*;
#(
  parameter int unsigned K    = KDefault,
  parameter int unsigned LOGK = LogKDefault
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] base,
  input  logic [K-1:0] exp,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] result,
  output logic         mm_start,
  output logic [K-1:0] mm_x,
  output logic [K-1:0] mm_y,
  input  logic [K-1:0] mm_z,
  input  logic         mm_done
);

  exp_state_e      state_q, state_d;
  logic [K-1:0]    base_q, base_d;
  logic [K-1:0]    exp_q, exp_d;
  logic [K-1:0]    acc_q, acc_d;
  logic [LOGK-1:0] idx_q, idx_d;
  logic            seen_q, seen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [K-1:0]    result_q, result_d;
  logic            mm_start_q, mm_start_d;
  logic [K-1:0]    mm_x_q, mm_x_d;
  logic [K-1:0]    mm_y_q, mm_y_d;
  logic            cur_bit;
  logic            last_bit;
  logic            mm_ack;

  assign cur_bit  = exp_q[idx_q];
  assign last_bit = (idx_q == '0);
  assign mm_ack   = mm_start_q & mm_done;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    mm_start_d = mm_start_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          idx_d   = LOGK'(K - 1);
          acc_d   = K'(1);
          seen_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (seen_q) begin
          mm_x_d     = acc_q;
          mm_y_d     = acc_q;
          mm_start_d = 1'b1;
          state_d    = StSq;
        end else begin
          // Leading ones need no multiply: acc is still 1, so it simply becomes base.
          if (cur_bit) begin
            acc_d  = base_q;
            seen_d = 1'b1;
          end
          if (last_bit) begin
            state_d = StFin;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      StSq: begin
        if (mm_ack) begin
          acc_d      = mm_z;
          mm_start_d = 1'b0;
          if (cur_bit) begin
            state_d = StMul;
          end else if (last_bit) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StScan;
          end
        end
      end
      StMul: begin
        // First MUL cycle is the mandatory low gap after the square request.
        if (!mm_start_q) begin
          mm_x_d     = acc_q;
          mm_y_d     = base_q;
          mm_start_d = 1'b1;
        end else if (mm_done) begin
          acc_d      = mm_z;
          mm_start_d = 1'b0;
          if (last_bit) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = StScan;
          end
        end
      end
      StFin: begin
        result_d = acc_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      exp_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      seen_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      mm_start_q <= 1'b0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      seen_q     <= seen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      mm_start_q <= mm_start_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_start = mm_start_q;
  assign mm_x     = mm_x_q;
  assign mm_y     = mm_y_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl driving a real mod_mul with m = 3551.
module tb_mod_exp_ctrl;
  import mod_arith_pkg::*;

  localparam int unsigned K    = 12;
  localparam int unsigned LOGK = 4;
  localparam int unsigned M    = 3551;
  localparam int          Tmo  = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [K-1:0] base_v;
  logic [K-1:0] exp_v;
  logic         busy;
  logic         done;
  logic [K-1:0] result;
  logic         mm_start;
  logic [K-1:0] mm_x;
  logic [K-1:0] mm_y;
  logic [K-1:0] mm_z;
  logic         mm_done;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.K(K), .LOGK(LOGK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base_v),
    .exp      (exp_v),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_start (mm_start),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_z     (mm_z),
    .mm_done  (mm_done)
  );

  mod_mul #(.K(K), .LOGK(LOGK), .M(M)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .x     (mm_x),
    .y     (mm_y),
    .z     (mm_z),
    .done  (mm_done)
  );

  int checks = 0;
  int failures = 0;
  int trans_cnt = 0;
  int done_cnt = 0;

  logic         prev_start = 1'b0;
  logic         prev_hs    = 1'b0;
  logic         prev_done  = 1'b0;
  logic [K-1:0] prev_x     = '0;
  logic [K-1:0] prev_y     = '0;

  // Cycle checker for handshake rules, plus transaction and done counters.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      prev_hs    = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_start && mm_start) begin
        checks++;
        if (mm_x !== prev_x || mm_y !== prev_y) begin
          failures++;
          $display("FAIL mm_xy_stable: x=%0d y=%0d required x=%0d y=%0d",
                   mm_x, mm_y, prev_x, prev_y);
        end
      end
      if (prev_hs) begin
        checks++;
        if (mm_start !== 1'b0) begin
          failures++;
          $display("FAIL mm_start_gap: mm_start=%b required 0", mm_start);
        end
      end
      if (prev_done) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL done_width: done=%b required 0", done);
        end
      end
      if (mm_start && !prev_start) trans_cnt++;
      if (done) done_cnt++;
      prev_start = mm_start;
      prev_hs    = mm_start && mm_done;
      prev_done  = done;
      prev_x     = mm_x;
      prev_y     = mm_y;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // One operation; interfere_at > 0 pulses a bogus start that many cycles in.
  task automatic run_op(input logic [K-1:0] b, input logic [K-1:0] e, input int interfere_at,
                        output int res, output int tr, output int dn, output bit to);
    @(negedge clk);
    trans_cnt = 0;
    done_cnt  = 0;
    base_v    = b;
    exp_v     = e;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to    = 1'b1;
    for (int i = 1; i < Tmo; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (i == interfere_at) begin
        base_v = 12'd5;
        exp_v  = 12'd7;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res   = int'(result);
    repeat (3) @(negedge clk);
    tr = trans_cnt;
    dn = done_cnt;
  endtask

  typedef struct {
    logic [K-1:0] b;
    logic [K-1:0] e;
    int           interfere_at;
    int           res;
    int           tr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int res;
    int tr;
    int dn;
    bit to;
    bit seen;

    vecs[0] = '{b: 12'd2,    e: 12'd10,   interfere_at: 0,  res: 1024, tr: 4};
    vecs[1] = '{b: 12'd2,    e: 12'd12,   interfere_at: 0,  res: 545,  tr: 4};
    vecs[2] = '{b: 12'd3550, e: 12'd3,    interfere_at: 0,  res: 3550, tr: 2};
    vecs[3] = '{b: 12'd2,    e: 12'd3432, interfere_at: 0,  res: 1,    tr: 16};
    vecs[4] = '{b: 12'd247,  e: 12'd0,    interfere_at: 0,  res: 1,    tr: 0};
    vecs[5] = '{b: 12'd247,  e: 12'd1,    interfere_at: 0,  res: 247,  tr: 0};
    vecs[6] = '{b: 12'd2,    e: 12'd12,   interfere_at: 30, res: 545,  tr: 4};

    rst    = 1'b1;
    start  = 1'b0;
    base_v = '0;
    exp_v  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_mm_start", int'(mm_start), 0);
    check("reset_mm_x", int'(mm_x), 0);
    check("reset_mm_y", int'(mm_y), 0);

    foreach (vecs[i]) begin
      run_op(vecs[i].b, vecs[i].e, vecs[i].interfere_at, res, tr, dn, to);
      check($sformatf("v%0d_timeout", i), int'(to), 0);
      check($sformatf("v%0d_result", i), res, vecs[i].res);
      check($sformatf("v%0d_transactions", i), tr, vecs[i].tr);
      check($sformatf("v%0d_done_pulses", i), dn, 1);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
    end

    // Start held high across done: a new operation begins the cycle after FIN.
    @(negedge clk);
    base_v = 12'd247;
    exp_v  = 12'd1;
    start  = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_first_done", int'(seen), 1);
    check("hold_first_result", int'(result), 247);
    check("hold_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("hold_restart_busy", int'(busy), 1);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < Tmo; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_second_done", int'(seen), 1);
    check("hold_second_result", int'(result), 247);

    // Reset while waiting on the first square.
    @(negedge clk);
    base_v = 12'd2;
    exp_v  = 12'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < Tmo; i++) begin
      if (mm_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_saw_request", int'(seen), 1);
    repeat (3) @(negedge clk);
    check("abort_waiting", int'(mm_start), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mm_start", int'(mm_start), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    rst = 1'b0;
    run_op(12'd2, 12'd10, 0, res, tr, dn, to);
    check("post_abort_timeout", int'(to), 0);
    check("post_abort_result", res, 1024);
    check("post_abort_transactions", tr, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
